// File: rtl/ahb_regslv.sv
// AHB responder for the rotate engine's register file: configuration, start control,
// and a sticky DONE status with interrupt. Optional wait states before every OKAY data phase.
module ahb_regslv #(
  parameter int P_WAIT = 0,
  parameter int P_AW   = 8
) (
  input  logic        I_AHBSLV_HCLK,
  input  logic        I_AHBSLV_HRESET_N,
  input  logic        I_AHBSLV_HSEL,
  input  logic [31:0] I_AHBSLV_HADDR,
  input  logic [1:0]  I_AHBSLV_HTRANS,
  input  logic        I_AHBSLV_HWRITE,
  input  logic [2:0]  I_AHBSLV_HSIZE,
  input  logic [31:0] I_AHBSLV_HWDATA,
  input  logic        I_AHBSLV_HREADY,
  input  logic        I_AHBSLV_BUSY,
  input  logic        I_AHBSLV_DONE,
  output logic [31:0] O_AHBSLV_HRDATA,
  output logic        O_AHBSLV_HREADYOUT,
  output logic [1:0]  O_AHBSLV_HRESP,
  output logic        O_AHBSLV_START,
  output logic [2:0]  O_AHBSLV_SIZE,
  output logic [31:0] O_AHBSLV_SRC,
  output logic [31:0] O_AHBSLV_DST,
  output logic [15:0] O_AHBSLV_WIDTH,
  output logic [15:0] O_AHBSLV_HEIGHT,
  output logic        O_AHBSLV_IRQ
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  localparam logic [P_AW-1:0] OFF_CTRL = P_AW'(8'h00);
  localparam logic [P_AW-1:0] OFF_SIZE = P_AW'(8'h04);
  localparam logic [P_AW-1:0] OFF_SRC  = P_AW'(8'h08);
  localparam logic [P_AW-1:0] OFF_DST  = P_AW'(8'h0C);
  localparam logic [P_AW-1:0] OFF_DIM  = P_AW'(8'h10);
  localparam logic [P_AW-1:0] OFF_STAT = P_AW'(8'h14);
  localparam logic [2:0]      WAIT_INIT = 3'(P_WAIT > 0 ? P_WAIT - 1 : 0);
  localparam logic [1:0]      RESP_OKAY = 2'b00;
  localparam logic [1:0]      RESP_ERR  = 2'b01;

  state_t          state_q, state_d;
  logic            hreadyout_q, hreadyout_d;
  logic [1:0]      hresp_q, hresp_d;
  logic [2:0]      wcnt_q, wcnt_d;
  logic [P_AW-1:0] addr_q, addr_d;
  logic            write_q, write_d;

  logic            ie_q, ie_d;
  logic [2:0]      size_q, size_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [15:0]     width_q, width_d;
  logic [15:0]     height_q, height_d;
  logic            done_q, done_d;
  logic            start_q, start_d;
  logic            irq_q, irq_d;

  logic [P_AW-1:0] off;
  logic            accept, in_map, addr_ok, wr_en, rd_en, w1c_done;
  logic [31:0]     wd, rdata;
  logic            unused_bits;

  assign unused_bits = ^{I_AHBSLV_HADDR[31:P_AW], I_AHBSLV_HTRANS[0]};

  assign off     = I_AHBSLV_HADDR[P_AW-1:0];
  assign accept  = I_AHBSLV_HSEL & I_AHBSLV_HREADY & I_AHBSLV_HTRANS[1];
  assign in_map  = off inside {OFF_CTRL, OFF_SIZE, OFF_SRC, OFF_DST, OFF_DIM, OFF_STAT};
  assign addr_ok = in_map & (off[1:0] == 2'b00) & (I_AHBSLV_HSIZE == 3'b010);

  // Data-phase sequencing; wait and error states hold HREADYOUT low so no new address is taken.
  always_comb begin
    state_d     = state_q;
    hreadyout_d = 1'b1;
    hresp_d     = RESP_OKAY;
    wcnt_d      = wcnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    case (state_q)
      S_WAIT: begin
        if (wcnt_q == 3'd0) begin
          state_d = S_DATA;
        end else begin
          hreadyout_d = 1'b0;
          wcnt_d      = wcnt_q - 3'd1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
        hresp_d = RESP_ERR;
      end
      default: begin
        if (accept) begin
          addr_d  = off;
          write_d = I_AHBSLV_HWRITE;
          if (!addr_ok) begin
            state_d     = S_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = RESP_ERR;
          end else if (P_WAIT > 0) begin
            state_d     = S_WAIT;
            hreadyout_d = 1'b0;
            wcnt_d      = WAIT_INIT;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  assign wd       = I_AHBSLV_HWDATA;
  assign wr_en    = (state_q == S_DATA) & write_q;
  assign rd_en    = (state_q == S_DATA) & ~write_q;
  assign w1c_done = wr_en & (addr_q == OFF_STAT) & wd[1];

  always_comb begin
    ie_d     = ie_q;
    size_d   = size_q;
    src_d    = src_q;
    dst_d    = dst_q;
    width_d  = width_q;
    height_d = height_q;
    start_d  = 1'b0;
    if (wr_en) begin
      case (addr_q)
        OFF_CTRL: begin
          ie_d    = wd[1];
          start_d = wd[0] & ~I_AHBSLV_BUSY;
        end
        OFF_SIZE: size_d = (wd[2:0] > 3'd2) ? 3'b010 : wd[2:0];
        OFF_SRC:  src_d  = wd;
        OFF_DST:  dst_d  = wd;
        OFF_DIM: begin
          width_d  = wd[15:0];
          height_d = wd[31:16];
        end
        default: ;
      endcase
    end
    // A completion pulse in the same cycle as the clearing write must not be lost.
    done_d = I_AHBSLV_DONE | (done_q & ~w1c_done);
    irq_d  = done_d & ie_d;
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (addr_q)
        OFF_CTRL: rdata = {30'b0, ie_q, 1'b0};
        OFF_SIZE: rdata = {29'b0, size_q};
        OFF_SRC:  rdata = src_q;
        OFF_DST:  rdata = dst_q;
        OFF_DIM:  rdata = {height_q, width_q};
        OFF_STAT: rdata = {30'b0, done_q, I_AHBSLV_BUSY};
        default:  rdata = '0;
      endcase
    end
  end

  always_ff @(posedge I_AHBSLV_HCLK or negedge I_AHBSLV_HRESET_N) begin
    if (!I_AHBSLV_HRESET_N) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
      wcnt_q      <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      ie_q        <= 1'b0;
      size_q      <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      width_q     <= '0;
      height_q    <= '0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      wcnt_q      <= wcnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      ie_q        <= ie_d;
      size_q      <= size_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      width_q     <= width_d;
      height_q    <= height_d;
      done_q      <= done_d;
      start_q     <= start_d;
      irq_q       <= irq_d;
    end
  end

  assign O_AHBSLV_HRDATA    = rdata;
  assign O_AHBSLV_HREADYOUT = hreadyout_q;
  assign O_AHBSLV_HRESP     = hresp_q;
  assign O_AHBSLV_START     = start_q;
  assign O_AHBSLV_SIZE      = size_q;
  assign O_AHBSLV_SRC       = src_q;
  assign O_AHBSLV_DST       = dst_q;
  assign O_AHBSLV_WIDTH     = width_q;
  assign O_AHBSLV_HEIGHT    = height_q;
  assign O_AHBSLV_IRQ       = irq_q;

endmodule

// File: tb/tb_ahb_regslv.sv
// Scoreboard bench for ahb_regslv: one instance with zero wait states, one with two,
// driven by a pipelined AHB master and checked against a register-map model.
module tb_ahb_regslv;

  localparam logic [7:0] A_CTRL = 8'h00, A_SIZE = 8'h04, A_SRC = 8'h08,
                         A_DST = 8'h0C, A_DIM = 8'h10, A_STAT = 8'h14;

  typedef struct {
    int          d;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic        gclk, grst_n;
  logic        hsel [2];
  logic [31:0] haddr [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize [2];
  logic [31:0] hwdata [2];
  logic        hready [2];
  logic        busy [2];
  logic        done [2];
  logic [31:0] hrdata [2];
  logic        hreadyout [2];
  logic [1:0]  hresp [2];
  logic        start [2];
  logic [2:0]  o_size [2];
  logic [31:0] o_src [2], o_dst [2];
  logic [15:0] o_w [2], o_h [2];
  logic        irq [2];

  int checks = 0, fails = 0;
  exp_t expq[$];
  exp_t mon_e;
  logic        dp [2];
  logic [15:0] nw [2];
  logic        sawerr [2];
  int          start_cnt [2];

  // Reference register state per instance
  logic        m_ie [2];
  logic [2:0]  m_size [2];
  logic [31:0] m_src [2], m_dst [2];
  logic [15:0] m_w [2], m_h [2];
  logic        m_done [2];

  assign hready[0] = hreadyout[0];
  assign hready[1] = hreadyout[1];

  ahb_regslv #(.P_WAIT(0), .P_AW(8)) u_dut0 (
    .I_AHBSLV_HCLK(gclk), .I_AHBSLV_HRESET_N(grst_n), .I_AHBSLV_HSEL(hsel[0]),
    .I_AHBSLV_HADDR(haddr[0]), .I_AHBSLV_HTRANS(htrans[0]), .I_AHBSLV_HWRITE(hwrite[0]),
    .I_AHBSLV_HSIZE(hsize[0]), .I_AHBSLV_HWDATA(hwdata[0]), .I_AHBSLV_HREADY(hready[0]),
    .I_AHBSLV_BUSY(busy[0]), .I_AHBSLV_DONE(done[0]), .O_AHBSLV_HRDATA(hrdata[0]),
    .O_AHBSLV_HREADYOUT(hreadyout[0]), .O_AHBSLV_HRESP(hresp[0]), .O_AHBSLV_START(start[0]),
    .O_AHBSLV_SIZE(o_size[0]), .O_AHBSLV_SRC(o_src[0]), .O_AHBSLV_DST(o_dst[0]),
    .O_AHBSLV_WIDTH(o_w[0]), .O_AHBSLV_HEIGHT(o_h[0]), .O_AHBSLV_IRQ(irq[0]));

  ahb_regslv #(.P_WAIT(2), .P_AW(8)) u_dut1 (
    .I_AHBSLV_HCLK(gclk), .I_AHBSLV_HRESET_N(grst_n), .I_AHBSLV_HSEL(hsel[1]),
    .I_AHBSLV_HADDR(haddr[1]), .I_AHBSLV_HTRANS(htrans[1]), .I_AHBSLV_HWRITE(hwrite[1]),
    .I_AHBSLV_HSIZE(hsize[1]), .I_AHBSLV_HWDATA(hwdata[1]), .I_AHBSLV_HREADY(hready[1]),
    .I_AHBSLV_BUSY(busy[1]), .I_AHBSLV_DONE(done[1]), .O_AHBSLV_HRDATA(hrdata[1]),
    .O_AHBSLV_HREADYOUT(hreadyout[1]), .O_AHBSLV_HRESP(hresp[1]), .O_AHBSLV_START(start[1]),
    .O_AHBSLV_SIZE(o_size[1]), .O_AHBSLV_SRC(o_src[1]), .O_AHBSLV_DST(o_dst[1]),
    .O_AHBSLV_WIDTH(o_w[1]), .O_AHBSLV_HEIGHT(o_h[1]), .O_AHBSLV_IRQ(irq[1]));

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_valid(logic [7:0] off, logic [2:0] sz);
    return (sz == 3'b010) && (off inside {A_CTRL, A_SIZE, A_SRC, A_DST, A_DIM, A_STAT});
  endfunction

  function automatic logic [31:0] model_read(int d, logic [7:0] off);
    case (off)
      A_CTRL:  return {30'b0, m_ie[d], 1'b0};
      A_SIZE:  return {29'b0, m_size[d]};
      A_SRC:   return m_src[d];
      A_DST:   return m_dst[d];
      A_DIM:   return {m_h[d], m_w[d]};
      A_STAT:  return {30'b0, m_done[d], busy[d]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(int d, logic [7:0] off, logic [31:0] v);
    case (off)
      A_CTRL: m_ie[d] = v[1];
      A_SIZE: m_size[d] = (v[2:0] >= 3'd3) ? 3'b010 : v[2:0];
      A_SRC:  m_src[d] = v;
      A_DST:  m_dst[d] = v;
      A_DIM:  begin m_w[d] = v[15:0]; m_h[d] = v[31:16]; end
      A_STAT: if (v[1]) m_done[d] = 1'b0;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ie[d] = 0; m_size[d] = 0; m_src[d] = 0; m_dst[d] = 0;
      m_w[d] = 0; m_h[d] = 0; m_done[d] = 0;
    end
  endtask

  // Present an address phase, push its expected response, and return once it has
  // been accepted (just after that edge) with the bus back to idle.
  task automatic send(int d, bit w, logic [31:0] a, logic [2:0] sz, logic [31:0] wd, logic [1:0] tr);
    exp_t e;
    int n;
    hsel[d] = 1; htrans[d] = tr; hwrite[d] = w; haddr[d] = a; hsize[d] = sz;
    e.d = d; e.err = !is_valid(a[7:0], sz); e.rd = !w;
    e.data = model_read(d, a[7:0]);
    expq.push_back(e);
    if (w && !e.err) model_write(d, a[7:0], wd);
    n = 0;
    do begin @(negedge gclk); n++; end while (!hreadyout[d] && n < 50);
    if (!hreadyout[d]) chk("accept_timeout", 0, 1);
    @(posedge gclk); #1;
    if (w) hwdata[d] = wd;
    hsel[d] = 0; htrans[d] = 2'b00;
  endtask

  // Let the outstanding data phase complete; optionally pulse DONE in its last cycle.
  task automatic xfer_end(int d, bit pulse);
    int n;
    n = 0;
    do begin @(negedge gclk); n++; end while (!hreadyout[d] && n < 50);
    if (!hreadyout[d]) chk("complete_timeout", 0, 1);
    if (pulse) done[d] = 1;
    @(posedge gclk); #1;
    done[d] = 0;
  endtask

  task automatic wr(int d, logic [7:0] off, logic [31:0] v);
    send(d, 1, {24'h0, off}, 3'b010, v, 2'b10);
    xfer_end(d, 0);
  endtask

  task automatic rd(int d, logic [7:0] off);
    send(d, 0, {24'h0, off}, 3'b010, 32'h0, 2'b10);
    xfer_end(d, 0);
  endtask

  task automatic idle(int k);
    repeat (k) @(posedge gclk);
    #1;
  endtask

  task automatic check_cfg(int d);
    chk("cfg_size", {29'b0, o_size[d]}, {29'b0, m_size[d]});
    chk("cfg_src", o_src[d], m_src[d]);
    chk("cfg_dst", o_dst[d], m_dst[d]);
    chk("cfg_dim", {o_h[d], o_w[d]}, {m_h[d], m_w[d]});
  endtask

  task automatic check_reset_state(int d);
    chk("rst_hrdata", hrdata[d], 0);
    chk("rst_hreadyout", {31'b0, hreadyout[d]}, 1);
    chk("rst_hresp", {30'b0, hresp[d]}, 0);
    chk("rst_start", {31'b0, start[d]}, 0);
    chk("rst_irq", {31'b0, irq[d]}, 0);
    check_cfg(d);
  endtask

  task automatic directed(int d);
    // back-to-back write then read
    send(d, 1, 32'h0000_0008, 3'b010, 32'h1000_0040, 2'b10);
    send(d, 0, 32'h0000_0008, 3'b010, 32'h0, 2'b10);
    xfer_end(d, 0);
    chk("src_out", o_src[d], 32'h1000_0040);
    wr(d, A_DIM, 32'h0100_0200);
    rd(d, A_DIM);
    chk("width", {16'h0, o_w[d]}, 32'h200);
    chk("height", {16'h0, o_h[d]}, 32'h100);
    // error responses; SIZE untouched
    send(d, 1, 32'h0000_0018, 3'b010, 32'h5, 2'b10);
    send(d, 1, 32'h0000_0004, 3'b000, 32'h5, 2'b10);
    xfer_end(d, 0);
    rd(d, A_SIZE);
    chk("size_after_err", {29'b0, o_size[d]}, 0);
    // START pulse when idle
    start_cnt[d] = 0;
    wr(d, A_CTRL, 32'h3);
    chk("start_hi", {31'b0, start[d]}, 1);
    idle(1);
    chk("start_lo", {31'b0, start[d]}, 0);
    idle(2);
    chk("start_cnt", start_cnt[d], 1);
    rd(d, A_CTRL);
    // no START while core busy
    busy[d] = 1;
    start_cnt[d] = 0;
    wr(d, A_CTRL, 32'h3);
    idle(3);
    chk("start_busy", start_cnt[d], 0);
    rd(d, A_STAT);
    busy[d] = 0;
    // DONE / IRQ
    done[d] = 1; @(posedge gclk); #1; done[d] = 0;
    m_done[d] = 1;
    chk("irq_set", {31'b0, irq[d]}, 1);
    rd(d, A_STAT);
    send(d, 1, {24'h0, A_STAT}, 3'b010, 32'h2, 2'b10);
    xfer_end(d, 1);
    m_done[d] = 1;
    rd(d, A_STAT);
    chk("irq_hold", {31'b0, irq[d]}, 1);
    wr(d, A_STAT, 32'h2);
    chk("irq_clr", {31'b0, irq[d]}, 0);
    rd(d, A_STAT);
    check_cfg(d);
  endtask

  task automatic random_phase(int d);
    logic [31:0] r, wd;
    logic [7:0]  off;
    logic [2:0]  sz;
    int k;
    busy[d] = 1'($urandom_range(0, 1));
    repeat (60) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          k = $urandom_range(0, 2);
          hsel[d] = (k != 2); htrans[d] = (k == 2) ? 2'b10 : 2'(k);
          @(posedge gclk); #1;
        end
        hsel[d] = 0; htrans[d] = 0;
      end
      r = $urandom();
      off = 8'(4 * $urandom_range(0, 5));
      sz = 3'b010;
      k = $urandom_range(0, 9);
      if (k == 0) off = 8'h18 + 8'(4 * $urandom_range(0, 57));
      else if (k == 1) off = off | 8'($urandom_range(1, 3));
      else if (k == 2) begin
        sz = 3'($urandom_range(3, 7));
        if ($urandom_range(0, 1) == 1) sz = 3'($urandom_range(0, 1));
      end
      wd = $urandom();
      send(d, 1'($urandom_range(0, 1)), {r[31:8], off}, sz, wd, 2'($urandom_range(2, 3)));
    end
    xfer_end(d, 0);
    busy[d] = 0;
    check_cfg(d);
  endtask

  // Monitor: tracks each accepted address into its data phase and scores the response.
  always @(negedge gclk) begin
    for (int d = 0; d < 2; d++) begin
      if (start[d]) start_cnt[d]++;
      if (!grst_n) dp[d] = 0;
      else begin
        if (dp[d]) begin
          if (!hreadyout[d]) begin
            nw[d]++;
            if (hresp[d] != 2'b00) sawerr[d] = 1;
          end else begin
            if (expq.size() == 0) chk("sb_empty", 1, 0);
            else begin
              mon_e = expq.pop_front();
              chk("rsp_ctl", {nw[d], 13'b0, sawerr[d], hresp[d]},
                  {(mon_e.err ? 16'd1 : (d == 1 ? 16'd2 : 16'd0)), 13'b0, mon_e.err,
                   (mon_e.err ? 2'b01 : 2'b00)});
              chk("rsp_data", hrdata[d], (mon_e.rd && !mon_e.err) ? mon_e.data : 32'h0);
            end
            dp[d] = 0;
          end
        end
        if (!dp[d] && hsel[d] && hready[d] && htrans[d][1]) begin
          dp[d] = 1; nw[d] = 0; sawerr[d] = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    grst_n = 0;
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 0; haddr[d] = 0; htrans[d] = 0; hwrite[d] = 0; hsize[d] = 0;
      hwdata[d] = 0; busy[d] = 0; done[d] = 0; dp[d] = 0; nw[d] = 0; sawerr[d] = 0;
      start_cnt[d] = 0;
    end
    model_reset();
    repeat (3) @(negedge gclk);
    grst_n = 1;
    @(posedge gclk); #1;
    check_reset_state(0);
    check_reset_state(1);

    directed(0);
    directed(1);
    random_phase(0);
    random_phase(1);

    // reset while the slow instance is stalling a DST write
    send(1, 1, {24'h0, A_DST}, 3'b010, 32'hDEAD_BEEF, 2'b10);
    chk("in_wait", {31'b0, hreadyout[1]}, 0);
    #2 grst_n = 0;
    expq.delete();
    model_reset();
    repeat (2) @(negedge gclk);
    chk("rst_dst", o_dst[1], 0);
    chk("rst_rdy", {31'b0, hreadyout[1]}, 1);
    grst_n = 1;
    idle(4);
    chk("post_rst_dst", o_dst[1], 0);
    chk("post_rst_rdy", {31'b0, hreadyout[1]}, 1);
    rd(1, A_DST);
    idle(2);
    chk("sb_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ahb_regslv.md
Name: ahb_regslv

Overview:
AHB slave (responder) holding the rotate engine's configuration and status registers. The external host master programs the block through it: source/destination addresses, transfer size and image dimensions, plus start control. The block drives the configuration and START inputs of the core and the master interface, and collects completion status into a sticky, interrupt-capable register. It responds to the same AHB protocol that the block's master interface initiates, from the responder side.

Parameters:
P_WAIT, 0, wait states (0-7) inserted before every OKAY data phase
P_AW, 8, number of HADDR low bits decoded; upper bits are qualified by HSEL

Ports:
I_AHBSLV_HCLK  in  1  clock
I_AHBSLV_HRESET_N  in  1  asynchronous active-low reset
I_AHBSLV_HSEL  in  1  slave select
I_AHBSLV_HADDR  in  32  address; only [P_AW-1:0] decoded
I_AHBSLV_HTRANS  in  2  transfer type
I_AHBSLV_HWRITE  in  1  1=write
I_AHBSLV_HSIZE  in  3  transfer size
I_AHBSLV_HWDATA  in  32  write data (data phase)
I_AHBSLV_HREADY  in  1  bus-wide HREADY
I_AHBSLV_BUSY  in  1  core busy level
I_AHBSLV_DONE  in  1  core completion pulse
O_AHBSLV_HRDATA  out  32  read data
O_AHBSLV_HREADYOUT  out  1  slave ready
O_AHBSLV_HRESP  out  2  00=OKAY, 01=ERROR
O_AHBSLV_START  out  1  one-cycle start pulse to core
O_AHBSLV_SIZE  out  3  CFG_SIZE[2:0]
O_AHBSLV_SRC  out  32  source base address
O_AHBSLV_DST  out  32  destination base address
O_AHBSLV_WIDTH  out  16  image width
O_AHBSLV_HEIGHT  out  16  image height
O_AHBSLV_IRQ  out  1  interrupt, DONE & IE

Behaviour:
- Reset: all registers 0; HRDATA=0, HREADYOUT=1, HRESP=00, START=0, IRQ=0; FSM=S_IDLE. Reset mid-transfer aborts the transfer immediately and discards any pending write.
- Register map, word offsets:
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IE (RW).
  - 0x04 SIZE: [2:0] RW. A written value of 3-7 is stored as 3'b010.
  - 0x08 SRC: RW.
  - 0x0C DST: RW.
  - 0x10 DIM: [15:0] WIDTH, [31:16] HEIGHT.
  - 0x14 STATUS: bit0 BUSY (RO, live input); bit1 DONE (sticky, W1C).
  - Unused bits read 0.
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. The block then captures the offset, HWRITE and a validity flag.
- Valid means: offset is in the map, offset[1:0]==0 and HSIZE==3'b010. Anything else is invalid.
- IDLE/BUSY HTRANS, or HSEL low: no action; next data phase is OKAY with zero wait.
- FSM states: S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2.
  - Accepted valid transfer with P_WAIT>0: S_WAIT. HREADYOUT=0 for P_WAIT cycles (3-bit counter), then S_DATA.
  - Accepted valid transfer with P_WAIT=0: directly S_DATA.
  - S_DATA: HREADYOUT=1, HRESP=OKAY. A write commits HWDATA at the end of this cycle. A new accepted address phase in the same cycle chains into the next transfer (back-to-back allowed).
  - Accepted invalid transfer: S_ERR1 (HREADYOUT=0, HRESP=01), then S_ERR2 (HREADYOUT=1, HRESP=01), then S_IDLE. Invalid writes modify nothing. Address phases presented during S_ERR1 are not accepted (HREADY low).
- Read data: HRDATA is driven with the addressed register during the cycle in which HREADYOUT=1 for an OKAY read, and 0 otherwise. BUSY is sampled live in that cycle.
- START: writing CTRL with bit0=1 while I_AHBSLV_BUSY=0 raises O_AHBSLV_START for exactly the one cycle after the write commits. The same write while BUSY=1 produces no pulse and is still answered OKAY; the IE bit is still updated.
- DONE: an I_AHBSLV_DONE pulse sets STATUS.DONE. Writing 1 to bit1 clears it. If set and clear occur in the same cycle, set wins. IRQ is registered: IRQ = DONE & IE, one cycle of latency.
- Config outputs are driven directly from the registers and update in the cycle after the write commits.

Test Plan:
- Reset, P_WAIT=0: write SRC=0x1000_0040 then read it back-to-back -> both OKAY with zero waits; HRDATA=0x1000_0040; O_AHBSLV_SRC=0x1000_0040.
- P_WAIT=2: read DIM after writing 0x0100_0200 -> HREADYOUT low for 2 cycles, then HRDATA=0x0100_0200; WIDTH=0x200, HEIGHT=0x100.
- Write offset 0x18, then a byte write (HSIZE=000) to 0x04 -> each gives the two-cycle ERROR (HREADYOUT 0 then 1, HRESP=01); SIZE stays 0.
- Write CTRL=0x3 with BUSY=0 -> START high for exactly 1 cycle and IE=1. Repeat with BUSY=1 -> no START pulse, OKAY response.
- DONE pulse with IE=1 -> STATUS reads 0x2 and IRQ=1 the next cycle. Write STATUS=0x2 coincident with a DONE pulse -> DONE stays 1. A later W1C clears DONE and IRQ.
- Assert reset during S_WAIT of a write to DST -> DST=0, HREADYOUT=1, no commit after reset is released.
